// File: rtl/mar_prog_seq_if.sv
// mar_prog_seq_if
//   Bundles the W-bus / front-panel inputs and the RAM-side outputs of the
//   memory address register sequencer.
//   master : drives nLm, prog, bus_in, sw_addr, auto_inc, wr_req;
//            observes addr, nrd, nwr, busy, wrapped.
//   slave  : the sequencer itself (mirror image of master).
interface mar_prog_seq_if #(
   parameter int ADDR_W = 4
);
   logic              nLm;       // active-low load MAR
   logic              prog;      // 1 = run, 0 = programming
   logic [ADDR_W-1:0] bus_in;    // W-bus address (run mode)
   logic [ADDR_W-1:0] sw_addr;   // front-panel address switches
   logic              auto_inc;  // programming: 1 = pointer, 0 = direct
   logic              wr_req;    // write request level, rising edge acts
   logic [ADDR_W-1:0] addr;      // registered RAM address
   logic              nrd;       // registered active-low RAM read
   logic              nwr;       // registered active-low RAM write strobe
   logic              busy;      // write sequence in progress
   logic              wrapped;   // pointer wrapped max -> 0 (one cycle)

   modport master (
      output nLm, prog, bus_in, sw_addr, auto_inc, wr_req,
      input  addr, nrd, nwr, busy, wrapped
   );

   modport slave (
      input  nLm, prog, bus_in, sw_addr, auto_inc, wr_req,
      output addr, nrd, nwr, busy, wrapped
   );
endinterface

// File: rtl/mar_prog_seq.sv
// mar_prog_seq
//   Memory address register with run and programming modes. In run mode the
//   address is latched from the W bus and the RAM is read continuously. In
//   programming mode the address comes from the front-panel switches (direct)
//   or an auto-incrementing pointer, and each rising edge of wr_req launches
//   a SETUP / STROBE (WR_PULSE cycles) / HOLD write sequence on nwr.
// Ports:
//   CLK  : system clock, all state changes on the rising edge
//   CLR  : synchronous active-high reset, overrides every other input
//   bus  : mar_prog_seq_if.slave (inputs nLm, prog, bus_in, sw_addr,
//          auto_inc, wr_req; registered outputs addr, nrd, nwr, busy,
//          wrapped)
// ADDR_W must match the ADDR_W of the connected interface instance.
module mar_prog_seq #(
   parameter int ADDR_W   = 4,
   parameter int WR_PULSE = 2   // 1..15
) (
   input logic          CLK,
   input logic          CLR,
   mar_prog_seq_if.slave bus
);

   localparam int CNT_W = 4;
   localparam logic [CNT_W-1:0]  PULSE_LAST = CNT_W'(WR_PULSE - 1);
   localparam logic [ADDR_W-1:0] ADDR_MAX   = '1;

   typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

   state_t            state, state_nxt;
   logic [CNT_W-1:0]  cnt, cnt_nxt;
   logic [ADDR_W-1:0] addr_q, addr_nxt;
   logic              nrd_q, nwr_q, busy_q, wrapped_q;
   logic              nwr_nxt, busy_nxt, wrapped_nxt;
   logic              wr_req_p1;
   logic              req;

   // One request per low-to-high transition of the level input.
   assign req = bus.wr_req & ~wr_req_p1;

   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      addr_nxt    = addr_q;
      wrapped_nxt = 1'b0;

      case (state)
         IDLE: begin
            if (bus.prog) begin
               // Run mode: requests are ignored, nLm loads from the W bus.
               if (!bus.nLm) addr_nxt = bus.bus_in;
            end else begin
               // Direct mode follows the switches every edge; pointer mode
               // loads only on nLm. A coincident request writes the new value.
               if (!bus.auto_inc || !bus.nLm) addr_nxt = bus.sw_addr;
               if (req) state_nxt = SETUP;
            end
         end
         SETUP: begin
            state_nxt = STROBE;
            cnt_nxt   = PULSE_LAST;
         end
         STROBE: begin
            if (cnt == '0) state_nxt = HOLD;
            else           cnt_nxt   = cnt - 1'b1;
         end
         HOLD: begin
            state_nxt = IDLE;
            // auto_inc as seen on the closing edge decides the increment.
            if (bus.auto_inc) begin
               addr_nxt    = addr_q + 1'b1;
               wrapped_nxt = (addr_q == ADDR_MAX);
            end
         end
         default: state_nxt = IDLE;
      endcase

      // Switching to run mode mid-sequence aborts without incrementing;
      // the run-mode load path stays live.
      if (bus.prog && (state != IDLE)) begin
         state_nxt   = IDLE;
         addr_nxt    = bus.nLm ? addr_q : bus.bus_in;
         wrapped_nxt = 1'b0;
      end

      // nwr is low exactly while the FSM sits in STROBE; since STROBE is
      // only reachable with prog=0, nrd (=~prog) is high at the same time.
      nwr_nxt  = (state_nxt != STROBE);
      busy_nxt = (state_nxt != IDLE);
   end

   // ---- register stage: FSM, counter, address and output strobes ----
   always_ff @(posedge CLK) begin
      if (CLR) begin
         state     <= IDLE;
         cnt       <= '0;
         wr_req_p1 <= 1'b0;
         addr_q    <= '0;
         nrd_q     <= 1'b1;
         nwr_q     <= 1'b1;
         busy_q    <= 1'b0;
         wrapped_q <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         wr_req_p1 <= bus.wr_req;
         addr_q    <= addr_nxt;
         nrd_q     <= ~bus.prog;
         nwr_q     <= nwr_nxt;
         busy_q    <= busy_nxt;
         wrapped_q <= wrapped_nxt;
      end
   end

   assign bus.addr    = addr_q;
   assign bus.nrd     = nrd_q;
   assign bus.nwr     = nwr_q;
   assign bus.busy    = busy_q;
   assign bus.wrapped = wrapped_q;

endmodule

// File: tb/tb_mar_prog_seq.sv
// tb_mar_prog_seq
//   Drives two sequencer instances (ADDR_W=4/WR_PULSE=2 and
//   ADDR_W=8/WR_PULSE=1) from one shared stimulus stream. A timeline model
//   (phase = edges since the accepted request) predicts every cycle's
//   outputs; predictions are queued at each edge and a monitor compares them
//   on the falling edge.
module tb_mar_prog_seq;

   localparam int AW0 = 4, WP0 = 2;
   localparam int AW1 = 8, WP1 = 1;

   logic CLK = 1'b0;
   logic CLR;
   always #5 CLK = ~CLK;

   logic       nLm, prog, auto_inc, wr_req;
   logic [7:0] bus_in, sw_addr;

   mar_prog_seq_if #(.ADDR_W(AW0)) if0 ();
   mar_prog_seq_if #(.ADDR_W(AW1)) if1 ();

   assign if0.nLm      = nLm;
   assign if0.prog     = prog;
   assign if0.auto_inc = auto_inc;
   assign if0.wr_req   = wr_req;
   assign if0.bus_in   = bus_in[3:0];
   assign if0.sw_addr  = sw_addr[3:0];
   assign if1.nLm      = nLm;
   assign if1.prog     = prog;
   assign if1.auto_inc = auto_inc;
   assign if1.wr_req   = wr_req;
   assign if1.bus_in   = bus_in;
   assign if1.sw_addr  = sw_addr;

   mar_prog_seq #(.ADDR_W(AW0), .WR_PULSE(WP0)) dut0 (.CLK(CLK), .CLR(CLR), .bus(if0.slave));
   mar_prog_seq #(.ADDR_W(AW1), .WR_PULSE(WP1)) dut1 (.CLK(CLK), .CLR(CLR), .bus(if1.slave));

   typedef struct packed {
      logic [7:0] addr;
      logic       nrd;
      logic       nwr;
      logic       busy;
      logic       wrapped;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];

   int n_chk  = 0;
   int n_fail = 0;

   // Reference model state, per instance.
   int m_addr[2];
   int m_ph[2];
   bit m_act[2];
   bit m_wrp[2];
   bit wq;

   task automatic model_step();
      bit req;
      req = wr_req && !wq;
      for (int i = 0; i < 2; i++) begin
         int   wp;
         int   mask;
         exp_t e;
         wp   = (i == 0) ? WP0 : WP1;
         mask = (i == 0) ? 'hF : 'hFF;
         m_wrp[i] = 1'b0;
         if (CLR) begin
            m_addr[i] = 0;
            m_act[i]  = 1'b0;
            m_ph[i]   = 0;
         end else if (m_act[i] && prog) begin
            m_act[i] = 1'b0;                         // abort, no increment
            if (!nLm) m_addr[i] = int'(bus_in) & mask;
         end else if (m_act[i]) begin
            m_ph[i]++;
            if (m_ph[i] == wp + 2) begin             // sequence complete
               m_act[i] = 1'b0;
               if (auto_inc) begin
                  m_wrp[i]  = (m_addr[i] == mask);
                  m_addr[i] = (m_addr[i] + 1) & mask;
               end
            end
         end else if (prog) begin
            if (!nLm) m_addr[i] = int'(bus_in) & mask;
         end else begin
            if (!auto_inc || !nLm) m_addr[i] = int'(sw_addr) & mask;
            if (req) begin
               m_act[i] = 1'b1;
               m_ph[i]  = 0;
            end
         end
         e.addr    = 8'(m_addr[i]);
         e.nrd     = CLR ? 1'b1 : !prog;
         e.nwr     = !(m_act[i] && (m_ph[i] >= 1) && (m_ph[i] <= wp));
         e.busy    = m_act[i];
         e.wrapped = m_wrp[i];
         if (i == 0) q0.push_back(e);
         else        q1.push_back(e);
      end
      wq = CLR ? 1'b0 : wr_req;
   endtask

   task automatic tick();
      @(posedge CLK);
      model_step();
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // Monitor: one prediction per instance per cycle.
   initial begin
      exp_t e, a;
      forever begin
         @(negedge CLK);
         if (q0.size() > 0) begin
            e = q0.pop_front();
            a = {4'h0, if0.addr, if0.nrd, if0.nwr, if0.busy, if0.wrapped};
            n_chk++;
            if (a !== e) begin
               n_fail++;
               $display("FAIL out4 t=%0t actual addr=%h nrd=%b nwr=%b busy=%b wrapped=%b required addr=%h nrd=%b nwr=%b busy=%b wrapped=%b",
                        $time, a.addr, a.nrd, a.nwr, a.busy, a.wrapped, e.addr, e.nrd, e.nwr, e.busy, e.wrapped);
            end
            n_chk++;
            if (!if0.nrd && !if0.nwr) begin
               n_fail++;
               $display("FAIL rdwr4 t=%0t actual nrd=0 nwr=0 required not both low", $time);
            end
         end
         if (q1.size() > 0) begin
            e = q1.pop_front();
            a = {if1.addr, if1.nrd, if1.nwr, if1.busy, if1.wrapped};
            n_chk++;
            if (a !== e) begin
               n_fail++;
               $display("FAIL out8 t=%0t actual addr=%h nrd=%b nwr=%b busy=%b wrapped=%b required addr=%h nrd=%b nwr=%b busy=%b wrapped=%b",
                        $time, a.addr, a.nrd, a.nwr, a.busy, a.wrapped, e.addr, e.nrd, e.nwr, e.busy, e.wrapped);
            end
            n_chk++;
            if (!if1.nrd && !if1.nwr) begin
               n_fail++;
               $display("FAIL rdwr8 t=%0t actual nrd=0 nwr=0 required not both low", $time);
            end
         end
      end
   end

   initial begin
      CLR = 1'b1; nLm = 1'b1; prog = 1'b1; auto_inc = 1'b0; wr_req = 1'b0;
      bus_in = 8'h00; sw_addr = 8'h00; wq = 1'b0;
      ticks(2);

      // Run-mode loads; a request must be ignored.
      CLR = 1'b0;
      bus_in = 8'h02; nLm = 1'b0; tick();
      nLm = 1'b1; tick();
      bus_in = 8'h05; nLm = 1'b0; tick();
      nLm = 1'b1; tick();
      wr_req = 1'b1; tick();
      wr_req = 1'b0; ticks(3);

      // Direct programming write at C.
      prog = 1'b0; auto_inc = 1'b0; sw_addr = 8'h0C; ticks(2);
      wr_req = 1'b1; ticks(2);
      wr_req = 1'b0; ticks(6);

      // Pointer mode, three writes across the wrap; switches must not matter.
      auto_inc = 1'b1; sw_addr = 8'hFE; nLm = 1'b0; tick();
      nLm = 1'b1; sw_addr = 8'h33; tick();
      for (int i = 0; i < 3; i++) begin
         wr_req = 1'b1; tick();
         wr_req = 1'b0; ticks(5);
      end

      // Busy rejection: second edge mid-sequence, then a long held level.
      wr_req = 1'b1; tick();
      wr_req = 1'b0; tick();
      wr_req = 1'b1; tick();
      wr_req = 1'b0; ticks(6);
      wr_req = 1'b1; ticks(10);
      wr_req = 1'b0; ticks(4);

      // Abort during STROBE at address 7.
      sw_addr = 8'h07; nLm = 1'b0; tick();
      nLm = 1'b1; tick();
      wr_req = 1'b1; tick();
      wr_req = 1'b0; tick();
      prog = 1'b1; ticks(3);
      prog = 1'b0; ticks(2);

      // Reset in the middle of a write.
      wr_req = 1'b1; tick();
      wr_req = 1'b0; tick();
      CLR = 1'b1; tick();
      CLR = 1'b0; ticks(3);

      // Load coincident with a request in pointer mode.
      auto_inc = 1'b1; sw_addr = 8'h09; nLm = 1'b0; wr_req = 1'b1; tick();
      nLm = 1'b1; wr_req = 1'b0; sw_addr = 8'h44; ticks(6);

      // Randomised traffic.
      for (int n = 0; n < 1500; n++) begin
         CLR = ($urandom_range(0, 63) == 0);
         if ($urandom_range(0, 19) == 0) prog = ~prog;
         if ($urandom_range(0, 15) == 0) auto_inc = ~auto_inc;
         nLm     = ($urandom_range(0, 3) != 0);
         wr_req  = ($urandom_range(0, 2) == 0);
         bus_in  = 8'($urandom);
         sw_addr = 8'($urandom);
         if ($urandom_range(0, 7) == 0) sw_addr = 8'hFF;
         tick();
      end
      CLR = 1'b0; wr_req = 1'b0; nLm = 1'b1;
      ticks(2);
      @(negedge CLK);
      #1;
      n_chk++;
      if ((q0.size() != 0) || (q1.size() != 0)) begin
         n_fail++;
         $display("FAIL drain actual pending=%0d/%0d required 0/0", q0.size(), q1.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/mar_prog_seq.md
Name: mar_prog_seq

Overview:
- Parametrised successor to the SAP-1 memory address register, with run and programming modes.
- Run mode: latches the address from the W bus on active-low nLm and drives continuous RAM read.
- Programming mode: takes the address from front-panel switches or an auto-incrementing pointer, and sequences RAM write strobes with setup, pulse and hold timing.
- Sits between the W bus / front panel and the RAM's address and nrd/nwr pins.

Parameters:
- ADDR_W, 4, address width in bits; memory depth is 2^ADDR_W.
- WR_PULSE, 2, cycles nwr is held low per write; legal range 1..15.

Ports:
- CLK  in  1  system clock; all state changes on rising edge.
- CLR  in  1  reset, synchronous, active-high.
- nLm  in  1  active-low load MAR.
- prog  in  1  mode select: 1 = run, 0 = programming.
- bus_in  in  ADDR_W  W-bus address source, used in run mode.
- sw_addr  in  ADDR_W  front-panel address switches.
- auto_inc  in  1  programming mode: 1 = pointer mode, 0 = direct switch mode.
- wr_req  in  1  write request, level input; acted on at its rising edge.
- addr  out  ADDR_W  registered RAM address.
- nrd  out  1  registered active-low RAM read enable.
- nwr  out  1  registered active-low RAM write strobe.
- busy  out  1  write sequence in progress.
- wrapped  out  1  one-cycle pulse when the auto-increment wraps from max to 0.

Behaviour:
- Reset (CLR=1 at an edge):
  - addr=0, nrd=1, nwr=1, busy=0, wrapped=0.
  - FSM=IDLE, pulse counter=0, wr_req history register=0.
  - CLR has priority over every other input.
- wr_req edge detect:
  - wr_req is registered each cycle.
  - A request is (wr_req=1 and previous sample=0).
  - A held-high wr_req produces exactly one request.
- Run mode (prog=1):
  - nrd goes to 0 one edge after prog is seen 1; nwr=1.
  - nLm=0 at an edge: addr <= bus_in.
  - nLm=1: addr holds.
  - Requests are ignored; FSM stays IDLE.
- Programming mode (prog=0):
  - nrd=1 one edge after prog is seen 0.
  - auto_inc=0 and FSM=IDLE: addr <= sw_addr every edge; nLm is ignored.
  - auto_inc=1 and FSM=IDLE: nLm=0 loads addr <= sw_addr; otherwise addr holds.
  - Outside IDLE, addr is frozen regardless of sw_addr or nLm.
- Write FSM, programming mode only:
  - IDLE: a request moves to SETUP on the same edge; busy=1 from that edge.
  - SETUP (1 cycle): nwr=1, addr stable. Next state STROBE; counter loads WR_PULSE-1.
  - STROBE (WR_PULSE cycles): nwr=0. Counter decrements; when it reaches 0, next state HOLD.
  - HOLD (1 cycle): nwr=1. Next state IDLE; busy=0 on that edge.
  - On the HOLD->IDLE edge with auto_inc=1: addr <= addr+1 modulo 2^ADDR_W. When addr was all-ones, wrapped=1 for exactly that cycle.
  - Timing for a request sampled at edge k: SETUP k; nwr low for edges k+1..k+WR_PULSE; HOLD k+WR_PULSE+1; IDLE k+WR_PULSE+2.
- Boundary cases:
  - A request while busy=1 is discarded; no queuing.
  - prog goes 1 during SETUP, STROBE or HOLD: abort. Next edge FSM=IDLE, nwr=1, busy=0, no increment, wrapped=0.
  - auto_inc changes mid-sequence: the value sampled on the HOLD->IDLE edge decides the increment.
  - nLm=0 coincident with a request in pointer mode: load takes effect, and that loaded address is the one written.
  - nwr and nrd are never both 0 in the same cycle.

Test Plan:
- Run-mode load:
  - Stimulus: CLR pulse, then prog=1, bus_in=4'h2, nLm=0 for 1 cycle, then bus_in=4'h5, nLm=0.
  - Required: addr=0 after reset, then 2, then 5; nrd=0, nwr=1 throughout; a wr_req pulse leaves busy=0.
- Direct programming write:
  - Stimulus: prog=0, auto_inc=0, sw_addr=4'hC, wr_req rises at edge k.
  - Required: nwr=0 exactly at edges k+1 and k+2; busy high k..k+3; addr=C constant; nrd=1.
- Pointer mode with wrap:
  - Stimulus: auto_inc=1, load sw_addr=4'hE via nLm, issue three requests spaced 6 cycles apart.
  - Required: writes at addresses E, F, 0; wrapped=1 for one cycle after the F write; final addr=1.
- Busy rejection:
  - Stimulus: second wr_req rising edge during STROBE; also wr_req held high for 10 cycles.
  - Required: only one nwr pulse each; addr increments once each.
- Abort:
  - Stimulus: prog=0 -> 1 during STROBE at addr 4'h7, auto_inc=1.
  - Required: next edge nwr=1, busy=0, addr=7 (no increment), nrd=0 one edge later.
- Reset mid-write plus a parameter sweep:
  - Stimulus: CLR during STROBE; repeat with ADDR_W=8, WR_PULSE=1.
  - Required: all outputs at reset values next edge; 8-bit wrap from FF to 00 pulses wrapped; nwr low exactly 1 cycle.
